// File: rtl/shift_des_pkg.sv
// rtl/shift_des_pkg.sv - shared states and constants for shift_deserializer
package shift_des_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_des_hold.sv
// rtl/shift_des_hold.sv - one-word holding register with valid/ack handshake and sticky overrun
module shift_des_hold
  import shift_des_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_perr,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_y,
  output logic             o_yv,
  output logic             o_ovf,
  output logic             o_perr
);

  logic [WIDTH-1:0] r_y;
  logic             r_yv;
  logic             r_ovf;
  logic             r_perr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y    <= '0;
      r_yv   <= 1'b0;
      r_ovf  <= 1'b0;
      r_perr <= 1'b0;
    end else if (i_load) begin
      // An ack in the completion cycle frees the slot, so the new word replaces the old one
      if (!r_yv || i_ack) begin
        r_y    <= i_word;
        r_yv   <= 1'b1;
        r_perr <= i_perr;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (i_ack && r_yv) begin
      r_yv <= 1'b0;
    end
  end

  assign o_y    = r_y;
  assign o_yv   = r_yv;
  assign o_ovf  = r_ovf;
  assign o_perr = r_perr;

endmodule

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial-to-parallel receiver, MSB- or LSB-first per frame
// Optional even parity bit per frame when SHIFT_DES_PARITY_EN is defined.
module shift_deserializer
  import shift_des_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             D,
  input  logic             DV,
  input  logic             SYNC,
  input  logic             LR,
  input  logic             ACK,
  output logic [WIDTH-1:0] Y,
  output logic             YV,
  output logic             OVF,
  output logic             PERR
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_lr;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;
  logic             w_perr;
  logic             w_start;
  logic             w_done;

  assign w_start   = DV & SYNC;
  assign w_shifted = (r_lr == LSB_FIRST) ? {D, r_shift[WIDTH-1:1]}
                                         : {r_shift[WIDTH-2:0], D};

`ifdef SHIFT_DES_PARITY_EN
  // Word is already complete when the parity bit arrives
  assign w_word = r_shift;
  assign w_perr = ^{r_shift, D};
`else
  assign w_word = w_shifted;
  assign w_perr = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_state <= HUNT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      HUNT: if (w_start) w_state_nxt = DATA;
      DATA: begin
        if (w_start) begin
          w_state_nxt = DATA;
        end else if (DV && (r_cnt == LAST_BIT)) begin
`ifdef SHIFT_DES_PARITY_EN
          w_state_nxt = PAR;
`else
          w_state_nxt = HUNT;
          w_done      = 1'b1;
`endif
        end
      end
      PAR: begin
        if (w_start) begin
          w_state_nxt = DATA;
        end else if (DV) begin
          w_state_nxt = HUNT;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_lr    <= MSB_FIRST;
    end else if (w_start) begin
      r_lr    <= LR;
      r_cnt   <= CW'(1);
      r_shift <= (LR == LSB_FIRST) ? {D, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, D};
    end else if (DV && (r_state == DATA)) begin
      r_shift <= w_shifted;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  shift_des_hold #(.WIDTH(WIDTH)) u_hold (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (w_done),
    .i_word (w_word),
    .i_perr (w_perr),
    .i_ack  (ACK),
    .o_y    (Y),
    .o_yv   (YV),
    .o_ovf  (OVF),
    .o_perr (PERR)
  );

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - scoreboard bench for shift_deserializer
// Parity cases run when SHIFT_DES_PARITY_EN is defined.
module tb_shift_deserializer;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             D;
  logic             DV;
  logic             SYNC;
  logic             LR;
  logic             ACK;
  logic [WIDTH-1:0] Y;
  logic             YV;
  logic             OVF;
  logic             PERR;

  int total = 0;
  int bad   = 0;

  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] exp;

  shift_deserializer #(.WIDTH(WIDTH)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .D    (D),
    .DV   (DV),
    .SYNC (SYNC),
    .LR   (LR),
    .ACK  (ACK),
    .Y    (Y),
    .YV   (YV),
    .OVF  (OVF),
    .PERR (PERR)
  );

  always #5 CLK = ~CLK;

  // Inputs change on the falling edge; outputs read after a tick reflect the previous rising edge
  task automatic tick(input logic dv, input logic d, input logic sync, input logic lr, input logic ack);
    @(negedge CLK);
    DV = dv; D = d; SYNC = sync; LR = lr; ACK = ack;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; DV = 1'b0; D = 1'b0; SYNC = 1'b0; LR = 1'b0; ACK = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // LR is inverted on non-SYNC bits so that only the SYNC-cycle value may matter
  task automatic send_word(input logic [WIDTH-1:0] w, input logic lr_i, input logic ack_last, input logic flip_par);
    logic b;
    logic last;
    for (int i = 0; i < WIDTH; i++) begin
      b    = lr_i ? w[i] : w[WIDTH-1-i];
`ifdef SHIFT_DES_PARITY_EN
      last = 1'b0;
`else
      last = (i == WIDTH - 1);
`endif
      tick(1'b1, b, i == 0, (i == 0) ? lr_i : ~lr_i, ack_last & last);
    end
`ifdef SHIFT_DES_PARITY_EN
    tick(1'b1, (^w) ^ flip_par, 1'b0, ~lr_i, ack_last);
`endif
  endtask

  task automatic test_reset();
    RST = 1'b1; DV = 1'b0; D = 1'b0; SYNC = 1'b0; LR = 1'b0; ACK = 1'b0;
    idle(); idle();
    total++; if (Y !== 8'h00) begin bad++; $display("FAIL reset_y got=%h exp=00", Y); end
    total++; if (YV !== 1'b0) begin bad++; $display("FAIL reset_yv got=%b exp=0", YV); end
    total++; if (OVF !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", OVF); end
    total++; if (PERR !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", PERR); end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_msb_first();
    exp_q.push_back({1'b0, 8'hA5});
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    total++; if (YV !== 1'b0) begin bad++; $display("FAIL msb_early_yv got=%b exp=0", YV); end
    idle();
    total++; if (YV !== 1'b1) begin bad++; $display("FAIL msb_yv got=%b exp=1", YV); end
    exp = exp_q.pop_front();
    total++; if ({PERR, Y} !== exp) begin bad++; $display("FAIL msb_word got=%h exp=%h", {PERR, Y}, exp); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    total++; if (YV !== 1'b0) begin bad++; $display("FAIL msb_ack_yv got=%b exp=0", YV); end
    total++; if (Y !== 8'hA5) begin bad++; $display("FAIL msb_hold_y got=%h exp=a5", Y); end
  endtask

  // Both frames carry the identical bit stream 0,0,0,0,0,0,0,1
  task automatic test_lsb_first();
    exp_q.push_back({1'b0, 8'h01});
    send_word(8'h01, 1'b0, 1'b0, 1'b0);
    idle();
    exp = exp_q.pop_front();
    total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL order_msb got=%h exp=%h", {YV, PERR, Y}, {1'b1, exp}); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({1'b0, 8'h80});
    send_word(8'h80, 1'b1, 1'b0, 1'b0);
    idle();
    exp = exp_q.pop_front();
    total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL order_lsb got=%h exp=%h", {YV, PERR, Y}, {1'b1, exp}); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    exp_q.push_back({1'b0, 8'h12});
    send_word(8'h12, 1'b0, 1'b0, 1'b0);
    idle();
    send_word(8'h34, 1'b0, 1'b0, 1'b0);
    idle();
    exp = exp_q.pop_front();
    total++; if ({PERR, Y} !== exp) begin bad++; $display("FAIL ovr_keep_y got=%h exp=%h", {PERR, Y}, exp); end
    total++; if (YV !== 1'b1) begin bad++; $display("FAIL ovr_yv got=%b exp=1", YV); end
    total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b exp=1", OVF); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(); idle();
    total++; if (YV !== 1'b0) begin bad++; $display("FAIL ovr_ack_yv got=%b exp=0", YV); end
    total++; if (OVF !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", OVF); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    total++; if (OVF !== 1'b0) begin bad++; $display("FAIL b2b_ovf_rst got=%b exp=0", OVF); end
    exp_q.push_back({1'b0, 8'h56});
    send_word(8'h56, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 8'h78});
    send_word(8'h78, 1'b0, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL b2b_first got=%h exp=%h", {YV, PERR, Y}, {1'b1, exp}); end
    idle();
    exp = exp_q.pop_front();
    total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", {YV, PERR, Y}, {1'b1, exp}); end
    total++; if (OVF !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%b exp=0", OVF); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w;
    logic             lr_r;
    for (int k = 0; k < 6; k++) begin
      w    = WIDTH'($urandom);
      lr_r = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, w});
      send_word(w, lr_r, 1'b0, 1'b0);
      idle();
      exp = exp_q.pop_front();
      total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL rand_%0d lr=%b got=%h exp=%h", k, lr_r, {YV, PERR, Y}, {1'b1, exp}); end
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_abort_gaps();
    logic [WIDTH-1:0] c;
    c = 8'hC3;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, c});
    for (int i = 0; i < WIDTH; i++) begin
      if (i > 0) tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick(1'b1, c[WIDTH-1-i], i == 0, 1'b0, 1'b0);
    end
`ifdef SHIFT_DES_PARITY_EN
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, ^c, 1'b0, 1'b0, 1'b0);
`endif
    total++; if (YV !== 1'b0) begin bad++; $display("FAIL abort_stale got=%b exp=0", YV); end
    idle();
    exp = exp_q.pop_front();
    total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL abort_word got=%h exp=%h", {YV, PERR, Y}, {1'b1, exp}); end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1; DV = 1'b1; D = 1'b1; SYNC = 1'b0;
    @(negedge CLK);
    RST = 1'b0; DV = 1'b0;
    total++; if ({YV, Y} !== 9'h000) begin bad++; $display("FAIL rst_mid got=%h exp=000", {YV, Y}); end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    total++; if (YV !== 1'b0) begin bad++; $display("FAIL rst_tail got=%b exp=0", YV); end
    exp_q.push_back({1'b0, 8'h3C});
    send_word(8'h3C, 1'b1, 1'b0, 1'b0);
    idle();
    exp = exp_q.pop_front();
    total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL rst_next got=%h exp=%h", {YV, PERR, Y}, {1'b1, exp}); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

`ifdef SHIFT_DES_PARITY_EN
  task automatic test_parity();
    exp_q.push_back({1'b0, 8'hA5});
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    idle();
    exp = exp_q.pop_front();
    total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL par_ok got=%h exp=%h", {YV, PERR, Y}, {1'b1, exp}); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({1'b1, 8'hA5});
    send_word(8'hA5, 1'b0, 1'b0, 1'b1);
    idle();
    exp = exp_q.pop_front();
    total++; if ({YV, PERR, Y} !== {1'b1, exp}) begin bad++; $display("FAIL par_err got=%h exp=%h", {YV, PERR, Y}, {1'b1, exp}); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_random();
    test_abort_gaps();
`ifdef SHIFT_DES_PARITY_EN
    test_parity();
`endif
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
